// File: rtl/jkdivbisqrt_ctrl_if.sv
// Request/response handshake bundle for the JK divide/sqrt controller.
// The controller binds the slave modport; binary-domain logic binds master.
interface jkdivbisqrt_ctrl_if #(
    parameter int BW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [BW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [BW-1:0] rsp_data;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jkdivbisqrt_ctrl.sv
// Sequencer for the JK unary divide/sqrt core: stream generation and counting.
// Optional warm-up phase enabled by defining JKDIVBISQRT_CTRL_WARMUP_EN.
module jkdivbisqrt_ctrl #(
    parameter int BW     = 8,
    parameter int WARMUP = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    jkdivbisqrt_ctrl_if.slave    bus,
    output logic                 busy,
    output logic                 core_rst_n,
    output logic                 core_in,
    input  logic                 core_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
`ifdef JKDIVBISQRT_CTRL_WARMUP_EN
    localparam logic [2:0] S_WARM  = 3'd2;
    localparam logic [BW:0] PH_WARM_LAST = (BW+1)'(WARMUP - 1);
`endif
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [BW:0] PH_RUN_LAST = (BW+1)'((2 ** BW) - 1);

    logic [2:0]    state;
    logic [BW-1:0] op_q;
    logic [BW-1:0] seq;
    logic [BW-1:0] seq_rev;
    logic [BW:0]   ph;
    logic [BW:0]   ones;
    logic [BW:0]   ones_nxt;
    logic [BW-1:0] ones_sat;
    logic [BW-1:0] rsp_data_q;
    logic          stream_en;

    // Bit-reversed counter gives a low-discrepancy threshold sequence.
    always_comb begin
        seq_rev = '0;
        for (int i = 0; i < BW; i++) begin
            seq_rev[i] = seq[BW-1-i];
        end
    end

    assign ones_nxt = ones + {{BW{1'b0}}, core_out};
    assign ones_sat = ones_nxt[BW] ? '1 : ones_nxt[BW-1:0];

`ifdef JKDIVBISQRT_CTRL_WARMUP_EN
    assign stream_en = (state == S_WARM) || (state == S_RUN);
`else
    assign stream_en = (state == S_RUN);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= '0;
            seq        <= '0;
            ph         <= '0;
            ones       <= '0;
            rsp_data_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= bus.req_data;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    seq  <= '0;
                    ph   <= '0;
                    ones <= '0;
`ifdef JKDIVBISQRT_CTRL_WARMUP_EN
                    state <= S_WARM;
`else
                    state <= S_RUN;
`endif
                end
`ifdef JKDIVBISQRT_CTRL_WARMUP_EN
                S_WARM: begin
                    seq <= seq + 1'b1;
                    if (ph == PH_WARM_LAST) begin
                        ph    <= '0;
                        state <= S_RUN;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
`endif
                S_RUN: begin
                    seq  <= seq + 1'b1;
                    ones <= ones_nxt;
                    if (ph == PH_RUN_LAST) begin
                        ph         <= '0;
                        rsp_data_q <= ones_sat;
                        state      <= S_DONE;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_DONE);
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state != S_IDLE);
    // Core is held in reset during CLEAR and while the controller is reset.
    assign core_rst_n    = !rst && (state != S_CLEAR);
    assign core_in       = stream_en && (op_q > seq_rev);

endmodule

// File: tb/tb_jkdivbisqrt_ctrl.sv
// Self-checking bench for jkdivbisqrt_ctrl with a behavioural stand-in core.
// Expected counts come from stream arithmetic and the bench's own core bits.
module tb_jkdivbisqrt_ctrl;

    localparam int BW     = 8;
    localparam int WARMUP = 16;
    localparam int N      = 1 << BW;
`ifdef JKDIVBISQRT_CTRL_WARMUP_EN
    localparam int WU = WARMUP;
`else
    localparam int WU = 0;
`endif
    localparam int LAT = 1 + WU + N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, core_rst_n, core_in, core_out;
    logic stuck = 1'b0;
    logic rmode = 1'b0;
    logic rbit  = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    jkdivbisqrt_ctrl_if #(.BW(BW)) bus ();

    jkdivbisqrt_ctrl #(.BW(BW), .WARMUP(WARMUP)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .busy       (busy),
        .core_rst_n (core_rst_n),
        .core_in    (core_in),
        .core_out   (core_out)
    );

    // Stand-in core: pass-through, random bits, or stuck high.
    assign core_out = stuck | (rmode ? rbit : core_in);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode 0: pass-through, 1: random core bits, 2: core stuck at 1
    task automatic do_op(input int op, input int mode,
                         input int hold, input bit keepv);
        int sum = 0;
        int in_ones = 0;
        int clr = 0;
        int bad = 0;
        int alt = 0;
        int hbad = 0;
        int expv;
        logic prev = 1'b0;
        logic [BW-1:0] opv;
        opv = BW'(op);
        @(negedge clk);
        #1;
        chk("req_ready_idle", int'(bus.req_ready), 1);
        stuck = (mode == 2);
        rmode = (mode == 1);
        bus.req_valid = 1'b1;
        bus.req_data  = opv;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            bus.req_valid = keepv;
            bus.req_data  = ~opv;
            rbit = 1'($urandom);
            #1;
            if (c > WU && c <= WU + N) begin
                sum     += int'(core_out);
                in_ones += int'(core_in);
                if (c > WU + 1 && core_in == prev) alt++;
                prev = core_in;
            end
            if (!core_rst_n) begin
                clr++;
                if (c != 0) bad++;
            end
            if (c == 0 && core_in) bad++;
            if (bus.rsp_valid || !busy || bus.req_ready) bad++;
        end
        if (mode == 0) expv = op;
        else expv = (sum > N - 1) ? N - 1 : sum;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("rsp_valid_latency", int'(bus.rsp_valid), 1);
        chk("rsp_data", int'(bus.rsp_data), expv);
        chk("done_req_ready", int'(bus.req_ready), 0);
        chk("done_core_in", int'(core_in), 0);
        chk("run_core_in_ones", in_ones, op);
        chk("clear_cycles", clr, 1);
        chk("busy_phase_flags", bad, 0);
        if (op == N / 2) chk("half_alternation", alt, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            if (!bus.rsp_valid || int'(bus.rsp_data) != expv || bus.req_ready)
                hbad++;
        end
        if (hold > 0) chk("backpressure_stable", hbad, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        chk("post_rsp_valid", int'(bus.rsp_valid), 0);
        chk("post_req_ready", int'(bus.req_ready), 1);
        chk("post_busy", int'(busy), 0);
    endtask

    initial begin
        int ops[3];
        int t_rsp[3];
        int d_rsp[3];
        int acc;
        int got;
        int bad;
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", int'(bus.req_ready), 1);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_core_rst_n", int'(core_rst_n), 0);
        chk("rst_core_in", int'(core_in), 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_core_rst_n", int'(core_rst_n), 1);

        do_op(0, 0, 0, 1'b0);
        do_op(255, 0, 0, 1'b0);
        do_op(255, 2, 0, 1'b0);
        do_op(128, 0, 0, 1'b1);
        do_op(64, 0, 0, 1'b0);
        do_op(144, 1, 0, 1'b0);
        do_op(200, 0, 50, 1'b1);
        for (int k = 0; k < 6; k++) begin
            do_op(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Asynchronous reset in the middle of RUN.
        stuck = 1'b0;
        rmode = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_data  = 8'd77;
        @(posedge clk);
        repeat (WU + 100) @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("midrun_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_req_ready", int'(bus.req_ready), 1);
        chk("arst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("arst_rsp_data", int'(bus.rsp_data), 0);
        chk("arst_core_rst_n", int'(core_rst_n), 0);
        chk("arst_core_in", int'(core_in), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < LAT + 5; c++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid || !bus.req_ready) bad++;
        end
        chk("after_rst_quiet", bad, 0);

        // Back-to-back with req_valid and rsp_ready held high.
        for (int i = 0; i < 3; i++) ops[i] = int'($urandom_range(0, N - 1));
        acc = 0;
        got = 0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 3 * (LAT + 2) + 50 && got < 3; c++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid) begin
                t_rsp[got] = cyc;
                d_rsp[got] = int'(bus.rsp_data);
                got++;
            end
            if (bus.req_ready) begin
                if (acc < 3) begin
                    bus.req_data  = BW'(ops[acc]);
                    bus.req_valid = 1'b1;
                    acc++;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        chk("b2b_count", got, 3);
        if (got == 3) begin
            for (int i = 0; i < 3; i++) chk("b2b_data", d_rsp[i], ops[i]);
            chk("b2b_spacing_1", t_rsp[1] - t_rsp[0], LAT + 2);
            chk("b2b_spacing_2", t_rsp[2] - t_rsp[1], LAT + 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
